// File: rtl/btn_event_arb.sv
// Push-button front end: shared sample tick, two-stage sampling, press detection,
// one pending event per button and round-robin hand-off over a valid/ready port.
module btn_event_arb #(
  parameter int unsigned N_BTN    = 4,
  parameter int unsigned DIV_BITS = 20,
  parameter int unsigned ID_W     = 2
) (
  input  logic             clk,
  input  logic             i_arst_n,
  input  logic [N_BTN-1:0] i_bin,
  output logic             o_tick,
  output logic             o_valid,
  output logic [ID_W-1:0]  o_id,
  input  logic             i_ready,
  output logic [N_BTN-1:0] o_overrun,
  input  logic             i_clr_ovr
);

  localparam logic [ID_W:0] NBtnW = (ID_W+1)'(N_BTN);

  logic [DIV_BITS-1:0] cnt_q, cnt_d;
  logic                tick_q, tick_d;
  logic [N_BTN-1:0]    s0_q, s1_q;
  logic                primed_q;
  logic                samp_q;
  logic [N_BTN-1:0]    press_q, press_d;
  logic [N_BTN-1:0]    pend_q, pend_d;
  logic [N_BTN-1:0]    ovr_q, ovr_d;
  logic [ID_W-1:0]     rr_q, rr_d;
  logic                valid_q, valid_d;
  logic [ID_W-1:0]     id_q, id_d;

  logic                loadable;
  logic                gnt_found;
  logic [ID_W-1:0]     gnt_idx;
  logic [ID_W:0]       cand;
  logic [ID_W:0]       gnt_nxt;
  logic [N_BTN-1:0]    clr_mask;

  // Tick is registered so it is high exactly while the counter holds all-ones.
  always_comb begin
    cnt_d  = cnt_q + DIV_BITS'(1);
    tick_d = &cnt_d;
  end

  // A press is a sampled high-to-low transition, looked at once per tick.
  always_comb begin
    press_d = samp_q ? (s1_q & ~s0_q) : '0;
  end

  // Round-robin search upward from rr_q, wrapping at N_BTN.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N_BTN; k++) begin
      cand = {1'b0, rr_q} + (ID_W+1)'(k);
      if (cand >= NBtnW) begin
        cand = cand - NBtnW;
      end
      if (!gnt_found && pend_q[cand[ID_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    loadable = ~valid_q | i_ready;
    gnt_nxt  = {1'b0, gnt_idx} + (ID_W+1)'(1);
    clr_mask = (loadable && gnt_found) ? (N_BTN'(1) << gnt_idx) : '0;

    // A new press on the bit being granted this edge re-arms it; set wins.
    pend_d = (pend_q & ~clr_mask) | press_q;
    ovr_d  = (i_clr_ovr ? '0 : ovr_q) | (press_q & pend_q & ~clr_mask);

    valid_d = valid_q;
    id_d    = id_q;
    rr_d    = rr_q;
    if (loadable) begin
      valid_d = gnt_found;
      if (gnt_found) begin
        id_d = gnt_idx;
        rr_d = (gnt_nxt == NBtnW) ? '0 : gnt_nxt[ID_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      s0_q     <= '1;
      s1_q     <= '1;
      primed_q <= 1'b0;
      samp_q   <= 1'b0;
      press_q  <= '0;
      pend_q   <= '0;
      ovr_q    <= '0;
      rr_q     <= '0;
      valid_q  <= 1'b0;
      id_q     <= '0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      if (tick_q) begin
        s0_q     <= i_bin;
        s1_q     <= s0_q;
        primed_q <= 1'b1;
      end
      // The first sample after reset only seeds history, so a button held
      // through reset does not look like a fresh press.
      samp_q  <= tick_q & primed_q;
      press_q <= press_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      rr_q    <= rr_d;
      valid_q <= valid_d;
      id_q    <= id_d;
    end
  end

  assign o_tick    = tick_q;
  assign o_valid   = valid_q;
  assign o_id      = id_q;
  assign o_overrun = ovr_q;

endmodule

// File: tb/tb_btn_event_arb.sv
// Directed bench for btn_event_arb; accepted event ids are checked against a
// queue of ids pushed when each press is driven.
module tb_btn_event_arb;

  localparam int unsigned NBtn    = 4;
  localparam int unsigned DivBits = 3;
  localparam int unsigned IdW     = 2;

  logic            clk = 1'b0;
  logic            i_arst_n;
  logic [NBtn-1:0] i_bin;
  logic            o_tick;
  logic            o_valid;
  logic [IdW-1:0]  o_id;
  logic            i_ready;
  logic [NBtn-1:0] o_overrun;
  logic            i_clr_ovr;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  int exp_hs = 0;
  int mon_exp;
  int exp_q[$];

  btn_event_arb #(
    .N_BTN   (NBtn),
    .DIV_BITS(DivBits),
    .ID_W    (IdW)
  ) dut (
    .clk      (clk),
    .i_arst_n (i_arst_n),
    .i_bin    (i_bin),
    .o_tick   (o_tick),
    .o_valid  (o_valid),
    .o_id     (o_id),
    .i_ready  (i_ready),
    .o_overrun(o_overrun),
    .i_clr_ovr(i_clr_ovr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the negedge just before a tick edge.
  task automatic wait_tick();
    int k = 0;
    @(negedge clk);
    while (o_tick !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("tick_wait", o_tick, 1);
  endtask

  task automatic push(input int id);
    exp_q.push_back(id);
    exp_hs++;
  endtask

  // Scoreboard: every accepted event must match the oldest expected id.
  always @(posedge clk) begin
    if (i_arst_n && o_valid && i_ready) begin
      hs_cnt++;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_event: observed id %0d expected no event", o_id);
      end
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        assert (int'(o_id) === mon_exp) else begin
          errors++;
          $error("FAIL event_id: observed %0d expected %0d", o_id, mon_exp);
        end
      end
    end
  end

  initial begin
    int last;
    int nt;
    int bad;
    int vseen;

    i_arst_n  = 1'b0;
    i_bin     = '1;
    i_ready   = 1'b0;
    i_clr_ovr = 1'b0;
    #12;
    check("rst_valid", o_valid, 0);
    check("rst_id", o_id, 0);
    check("rst_tick", o_tick, 0);
    check("rst_ovr", o_overrun, 0);
    @(negedge clk);
    i_arst_n = 1'b1;

    // Idle: tick every 8 cycles, no events.
    last = -1; nt = 0; bad = 0; vseen = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (o_tick === 1'b1) begin
        if (last >= 0 && i - last != 8) bad++;
        last = i;
        nt++;
      end
      if (o_valid !== 1'b0) vseen++;
    end
    check("idle_tick_count", nt, 8);
    check("idle_tick_period", bad, 0);
    check("idle_valid", vseen, 0);
    check("idle_ovr", o_overrun, 0);

    // Buttons 0,1,3 on one tick, consumer stalled, then drained back-to-back.
    wait_tick();
    i_bin = 4'b0100;
    push(0); push(1); push(3);
    step(4);
    check("multi_first_valid", o_valid, 1);
    check("multi_first_id", o_id, 0);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!(o_valid === 1'b1 && o_id === 2'd0)) bad++;
    end
    check("multi_stall_stable", bad, 0);
    i_ready = 1'b1;
    step(1);
    check("multi_b2b_valid1", o_valid, 1);
    check("multi_b2b_id1", o_id, 1);
    step(1);
    check("multi_b2b_valid3", o_valid, 1);
    check("multi_b2b_id3", o_id, 3);
    step(1);
    check("multi_drained_valid", o_valid, 0);
    check("multi_drained_id_hold", o_id, 3);
    i_bin = '1;
    step(24);
    check("multi_hs_count", hs_cnt, exp_hs);

    // Single press on button 2: o_valid rises exactly 3 edges after the tick edge.
    wait_tick();
    i_bin = 4'b1011;
    push(2);
    step(1);
    check("lat_T", o_valid, 0);
    step(1);
    check("lat_T1", o_valid, 0);
    step(1);
    check("lat_T2", o_valid, 0);
    step(1);
    check("lat_T3_valid", o_valid, 1);
    check("lat_T3_id", o_id, 2);
    step(1);
    check("lat_T4_valid", o_valid, 0);
    step(24);
    i_bin = '1;
    step(24);
    check("hold_release_hs", hs_cnt, exp_hs);

    // Bounce on button 1 between ticks, then held low: one event.
    wait_tick();
    step(1);
    i_bin[1] = 1'b0;
    push(1);
    step(2);
    i_bin[1] = 1'b1;
    step(2);
    i_bin[1] = 1'b0;
    step(30);
    i_bin = '1;
    step(24);
    check("bounce_hs", hs_cnt, exp_hs);
    check("bounce_queue", exp_q.size(), 0);

    // Pointer now 2: buttons 0 and 3 together grant 3 first.
    wait_tick();
    i_bin = 4'b0110;
    push(3); push(0);
    step(4);
    check("rr_first_valid", o_valid, 1);
    check("rr_first_id", o_id, 3);
    step(1);
    check("rr_second_id", o_id, 0);
    step(1);
    check("rr_done_valid", o_valid, 0);
    i_bin = '1;
    step(24);

    // Overrun: output busy with 0, button 1 pending, then pressed again.
    i_ready = 1'b0;
    wait_tick();
    i_bin = 4'b1110;
    push(0);
    step(4);
    check("ovr_busy_id", o_id, 0);
    wait_tick();
    i_bin = 4'b1100;
    push(1);
    step(4);
    check("ovr_first_press", o_overrun, 0);
    wait_tick();
    i_bin = 4'b1110;
    wait_tick();
    i_bin = 4'b1100;
    step(4);
    check("ovr_set", o_overrun, 4'b0010);
    i_clr_ovr = 1'b1;
    step(1);
    i_clr_ovr = 1'b0;
    check("ovr_clear", o_overrun, 0);
    i_ready = 1'b1;
    step(1);
    check("ovr_drain_valid", o_valid, 1);
    check("ovr_drain_id", o_id, 1);
    step(1);
    check("ovr_drain_done", o_valid, 0);
    i_bin = '1;
    step(24);
    check("ovr_hs", hs_cnt, exp_hs);

    // Asynchronous reset while an event is offered and another is pending.
    i_ready = 1'b0;
    wait_tick();
    i_bin = 4'b1110;
    push(0);
    step(4);
    check("arst_pre_valid", o_valid, 1);
    wait_tick();
    i_bin = 4'b1010;
    wait_tick();
    i_bin = 4'b1110;
    wait_tick();
    i_bin = 4'b1010;
    step(4);
    check("arst_pre_ovr", o_overrun, 4'b0100);
    #2;
    i_arst_n = 1'b0;
    #1;
    check("arst_valid", o_valid, 0);
    check("arst_ovr", o_overrun, 0);
    check("arst_id", o_id, 0);
    exp_hs = exp_hs - exp_q.size();
    exp_q.delete();
    @(negedge clk);
    i_arst_n = 1'b1;
    i_ready  = 1'b1;
    step(40);
    check("held_thru_reset_hs", hs_cnt, exp_hs);
    i_bin = '1;
    step(24);
    wait_tick();
    i_bin = 4'b1011;
    push(2);
    step(4);
    check("post_rst_valid", o_valid, 1);
    check("post_rst_id", o_id, 2);
    step(1);
    check("final_hs", hs_cnt, exp_hs);
    check("final_queue", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
